// File: rtl/instr_mem_loadable_if.sv
// Fetch and program-load bus between the IF stage/loader and the loadable instruction memory.
// The master drives requests and load words; the slave returns fetched instructions and load status.
interface instr_mem_loadable_if #(
    parameter int DATA_W = 32
);
    logic              rd_en;
    logic [31:0]       rd_addr;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] instr;
    logic              instr_vld;
    logic              addr_err;
    logic              ld_start;
    logic [DATA_W-1:0] ld_data;
    logic              ld_valid;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;

    modport master (
        output rd_en, rd_addr, stall, flush, ld_start, ld_data, ld_valid, ld_last,
        input  instr, instr_vld, addr_err, ld_ready, ld_done
    );

    modport slave (
        input  rd_en, rd_addr, stall, flush, ld_start, ld_data, ld_valid, ld_last,
        output instr, instr_vld, addr_err, ld_ready, ld_done
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// Word-addressed instruction memory with a 1-cycle registered fetch (stall/flush aware)
// and a streaming load port that writes a program from word 0 at run time.
module instr_mem_loadable #(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 8,
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    instr_mem_loadable_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_wptr;
    logic              r_ld_done;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_instr_vld;
    logic              r_addr_err;

    logic              w_wr;
    logic              w_ld_fin;
    logic [ADDR_W-1:0] w_idx;
    logic              w_fetch_err;
    logic              w_capture;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_wr     = (r_state == ST_LOAD) && bus.ld_valid;
    // Final slot always ends the load; the write pointer never wraps into word 0.
    assign w_ld_fin = w_wr && (bus.ld_last || (&r_wptr));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (bus.ld_start) w_state_next = ST_LOAD;
            ST_LOAD: if (w_ld_fin)     w_state_next = ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= ST_RUN;
            r_wptr    <= '0;
            r_ld_done <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ld_done <= w_ld_fin;
            if (r_state == ST_RUN && bus.ld_start) begin
                r_wptr <= '0;
            end else if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
        end
    end

    assign bus.ld_ready = (r_state == ST_LOAD);
    assign bus.ld_done  = r_ld_done;

    // Storage is deliberately not reset so a loaded program survives a CPU reset.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= bus.ld_data;
        end
    end

    assign w_idx       = bus.rd_addr[ADDR_W+1:2];
    assign w_fetch_err = (bus.rd_addr[1:0] != 2'b00) || (|bus.rd_addr[31:ADDR_W+2]);
    assign w_capture   = (r_state == ST_RUN) && !bus.flush && !bus.stall
                         && bus.rd_en && !w_fetch_err;

    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            r_rd_data <= r_mem[w_idx];
        end
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_instr_vld <= 1'b0;
            r_addr_err  <= 1'b0;
        end else if (r_state == ST_LOAD || bus.flush) begin
            r_instr_vld <= 1'b0;
            r_addr_err  <= 1'b0;
        end else if (bus.stall) begin
            r_instr_vld <= r_instr_vld;
            r_addr_err  <= r_addr_err;
        end else if (bus.rd_en) begin
            r_instr_vld <= !w_fetch_err;
            r_addr_err  <= w_fetch_err;
        end else begin
            r_instr_vld <= 1'b0;
            r_addr_err  <= 1'b0;
        end
    end

    // The data register only moves on good fetches, so the valid flag gates it to NOP.
    assign bus.instr     = r_instr_vld ? r_rd_data : NOP;
    assign bus.instr_vld = r_instr_vld;
    assign bus.addr_err  = r_addr_err;

endmodule
